l2_port_arbiter: RTL and testbench

- Shares the single L2 request port between three L1 requesters: IL1 refill, DL1 refill and DL1 dirty writeback.
- Sits between IL1_Cache/DL1_Cache and L2_Cache.
- Serialises accesses one at a time, registering the winning address and op toward L2.
- Applies fixed priority with an aging override so IL1 cannot starve, and flags an L2 that never acknowledges.

---
 rtl/l2_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_l2_port_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/l2_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// l2_port_arbiter: shares the L2 request port between IL1 refill, DL1 refill
// and DL1 writeback, using fixed priority with inst aging and a timeout flag.
// Revision: 1.0
// ----------------------------------------------------------------------------
module l2_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              data_req,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic              wb_req,
    input  logic [ADDR_W-1:0] wb_addr,
    output logic              inst_ack,
    output logic              data_ack,
    output logic              wb_ack,
    output logic              l2_req,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [1:0]        l2_op,
    input  logic              l2_ack,
    output logic              arb_busy,
    output logic              timeout_err
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] C_WAIT_MAX = WAIT_W'(MAX_WAIT);

    localparam logic [1:0] OP_INST = 2'b00;
    localparam logic [1:0] OP_DATA = 2'b01;
    localparam logic [1:0] OP_WB   = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic                l2_req_q;
    logic [ADDR_W-1:0]   l2_addr_q;
    logic [1:0]          l2_op_q;
    logic                inst_ack_q;
    logic                data_ack_q;
    logic                wb_ack_q;
    logic                arb_busy_q;
    logic [WAIT_W-1:0]   wait_cnt_q;

    logic                any_req;
    logic [1:0]          l2_op_d;
    logic [ADDR_W-1:0]   l2_addr_d;
    logic [WAIT_W-1:0]   wait_cnt_d;

    // Winner selection; only consumed when the FSM is in IDLE.
    always_comb begin
        any_req   = inst_req | data_req | wb_req;
        l2_op_d   = OP_INST;
        l2_addr_d = inst_addr;
        if (inst_req && (wait_cnt_q == C_WAIT_MAX)) begin
            l2_op_d   = OP_INST;
            l2_addr_d = inst_addr;
        end else if (wb_req) begin
            l2_op_d   = OP_WB;
            l2_addr_d = wb_addr;
        end else if (data_req) begin
            l2_op_d   = OP_DATA;
            l2_addr_d = data_addr;
        end

        wait_cnt_d = wait_cnt_q;
        if (l2_op_d == OP_INST) begin
            wait_cnt_d = '0;
        end else if (inst_req && (wait_cnt_q != C_WAIT_MAX)) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            l2_req_q   <= 1'b0;
            l2_addr_q  <= '0;
            l2_op_q    <= OP_INST;
            inst_ack_q <= 1'b0;
            data_ack_q <= 1'b0;
            wb_ack_q   <= 1'b0;
            arb_busy_q <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            inst_ack_q <= 1'b0;
            data_ack_q <= 1'b0;
            wb_ack_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q    <= BUSY;
                        l2_req_q   <= 1'b1;
                        l2_addr_q  <= l2_addr_d;
                        l2_op_q    <= l2_op_d;
                        arb_busy_q <= 1'b1;
                        wait_cnt_q <= wait_cnt_d;
                    end
                end
                BUSY: begin
                    if (l2_ack) begin
                        state_q    <= DONE;
                        l2_req_q   <= 1'b0;
                        inst_ack_q <= (l2_op_q == OP_INST);
                        data_ack_q <= (l2_op_q == OP_DATA);
                        wb_ack_q   <= (l2_op_q == OP_WB);
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    arb_busy_q <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    l2_req_q   <= 1'b0;
                    arb_busy_q <= 1'b0;
                end
            endcase
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_timeout
            localparam int TO_W = $clog2(TIMEOUT + 1);
            localparam logic [TO_W-1:0] C_TO_MAX = TO_W'(TIMEOUT);

            logic [TO_W-1:0] to_cnt_q;
            logic            timeout_err_q;

            // Flag rises on the edge where the BUSY count reaches TIMEOUT.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    to_cnt_q      <= '0;
                    timeout_err_q <= 1'b0;
                end else if ((state_q == IDLE) && any_req) begin
                    to_cnt_q <= '0;
                end else if ((state_q == BUSY) && !l2_ack && (to_cnt_q != C_TO_MAX)) begin
                    to_cnt_q <= to_cnt_q + TO_W'(1);
                    if (to_cnt_q == (C_TO_MAX - TO_W'(1))) begin
                        timeout_err_q <= 1'b1;
                    end
                end
            end

            assign timeout_err = timeout_err_q;
        end else begin : g_no_timeout
            assign timeout_err = 1'b0;
        end
    endgenerate

    assign inst_ack = inst_ack_q;
    assign data_ack = data_ack_q;
    assign wb_ack   = wb_ack_q;
    assign l2_req   = l2_req_q;
    assign l2_addr  = l2_addr_q;
    assign l2_op    = l2_op_q;
    assign arb_busy = arb_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_l2_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_l2_port_arbiter: directed vector table plus hand-written sequences for
// ordering, aging, spurious ack, withdrawn request, timeout and async reset.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_l2_port_arbiter;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              inst_req = 1'b0, data_req = 1'b0, wb_req = 1'b0;
    logic [ADDR_W-1:0] inst_addr = '0, data_addr = '0, wb_addr = '0;
    logic              inst_ack, data_ack, wb_ack;
    logic              l2_req;
    logic [ADDR_W-1:0] l2_addr;
    logic [1:0]        l2_op;
    logic              l2_ack = 1'b0;
    logic              arb_busy, timeout_err;

    int tests = 0;
    int fails = 0;

    l2_port_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .data_req(data_req), .data_addr(data_addr),
        .wb_req(wb_req), .wb_addr(wb_addr),
        .inst_ack(inst_ack), .data_ack(data_ack), .wb_ack(wb_ack),
        .l2_req(l2_req), .l2_addr(l2_addr), .l2_op(l2_op), .l2_ack(l2_ack),
        .arb_busy(arb_busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        inst, data, wb;
        logic [31:0] ia, da, wa;
        logic [1:0]  op;
        logic [31:0] addr;
        logic [2:0]  ack;   // {inst, data, wb}
        int          dly;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_l2_req(input string name);
        int n = 0;
        while (!l2_req && n < 20) begin
            tick();
            n++;
        end
        check({name, "_l2req_seen"}, 64'(l2_req), 64'd1);
    endtask

    // Pulse l2_ack for one cycle; returns in the cycle after the pulse.
    task automatic pulse_ack();
        l2_ack = 1'b1;
        tick();
        l2_ack = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h1000, 32'h0,    32'h0,    2'b00, 32'h1000, 3'b100, 3};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0,    32'h3000, 32'h0,    2'b01, 32'h3000, 3'b010, 2};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0,    32'h0,    32'h4000, 2'b10, 32'h4000, 3'b001, 1};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0,    32'h3100, 32'h5000, 2'b10, 32'h5000, 3'b001, 2};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h1100, 32'h3200, 32'h0,    2'b01, 32'h3200, 3'b010, 4};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h1200, 32'h0,    32'h0,    2'b00, 32'h1200, 3'b100, 1};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h1300, 32'h3300, 32'h5100, 2'b10, 32'h5100, 3'b001, 5};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 32'h1400, 32'h0,    32'h5200, 2'b10, 32'h5200, 3'b001, 2};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 32'h1500, 32'h0,    32'h0,    2'b00, 32'h1500, 3'b100, 3};

        // Reset state
        #12;
        check("rst_l2_req", 64'(l2_req), 64'd0);
        check("rst_l2_addr", 64'(l2_addr), 64'd0);
        check("rst_l2_op", 64'(l2_op), 64'd0);
        check("rst_acks", 64'({inst_ack, data_ack, wb_ack}), 64'd0);
        check("rst_busy_err", 64'({arb_busy, timeout_err}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Table: single transactions from IDLE
        for (int i = 0; i < 9; i++) begin
            inst_req = vecs[i].inst; data_req = vecs[i].data; wb_req = vecs[i].wb;
            inst_addr = vecs[i].ia;  data_addr = vecs[i].da;  wb_addr = vecs[i].wa;
            tick();
            check($sformatf("v%0d_l2_req", i), 64'(l2_req), 64'd1);
            check($sformatf("v%0d_op", i), 64'(l2_op), 64'(vecs[i].op));
            check($sformatf("v%0d_addr", i), 64'(l2_addr), 64'(vecs[i].addr));
            for (int d = 0; d < vecs[i].dly; d++) tick();
            check($sformatf("v%0d_hold", i), 64'({l2_req, l2_op, l2_addr}),
                  64'({1'b1, vecs[i].op, vecs[i].addr}));
            pulse_ack();
            inst_req = 1'b0; data_req = 1'b0; wb_req = 1'b0;
            check($sformatf("v%0d_ack", i), 64'({inst_ack, data_ack, wb_ack}), 64'(vecs[i].ack));
            check($sformatf("v%0d_done", i), 64'({l2_req, arb_busy}), 64'b01);
            tick();
            check($sformatf("v%0d_idle", i), 64'({inst_ack, data_ack, wb_ack, arb_busy}), 64'd0);
        end

        // Ordering: wb before data, data l2_req 3 cycles after wb l2_ack
        wb_req = 1'b1; wb_addr = 32'h2000; data_req = 1'b1; data_addr = 32'h2000;
        tick();
        check("ord_first_op", 64'(l2_op), 64'b10);
        tick();
        pulse_ack();
        wb_req = 1'b0;
        check("ord_wb_ack", 64'({inst_ack, data_ack, wb_ack}), 64'b001);
        tick();
        check("ord_gap_req", 64'(l2_req), 64'd0);
        tick();
        check("ord_data_req", 64'({l2_req, l2_op}), 64'b101);
        pulse_ack();
        data_req = 1'b0;
        check("ord_data_ack", 64'({inst_ack, data_ack, wb_ack}), 64'b010);
        tick(); tick();

        // Aging: inst held, wb always pending
        inst_req = 1'b1; inst_addr = 32'h1800; wb_req = 1'b1; wb_addr = 32'h6000;
        for (int g = 0; g < 6; g++) begin
            wait_l2_req($sformatf("age%0d", g));
            check($sformatf("age%0d_op", g), 64'(l2_op), (g == 4) ? 64'b00 : 64'b10);
            pulse_ack();
            check($sformatf("age%0d_ack", g), 64'({inst_ack, data_ack, wb_ack}),
                  (g == 4) ? 64'b100 : 64'b001);
        end
        inst_req = 1'b0; wb_req = 1'b0;
        tick(); tick();

        // Spurious l2_ack in IDLE
        pulse_ack();
        check("spur_acks", 64'({inst_ack, data_ack, wb_ack, l2_req, arb_busy}), 64'd0);
        tick();
        check("spur_idle", 64'({l2_req, arb_busy}), 64'd0);

        // Withdrawn data request still completes
        data_req = 1'b1; data_addr = 32'h7000;
        tick();
        data_req = 1'b0;
        check("wd_grant", 64'({l2_req, l2_op}), 64'b101);
        tick(); tick();
        check("wd_hold", 64'({l2_req, l2_addr}), 64'({1'b1, 32'h7000}));
        pulse_ack();
        check("wd_data_ack", 64'({inst_ack, data_ack, wb_ack}), 64'b010);
        tick();

        // Timeout after 8 BUSY cycles without l2_ack
        inst_req = 1'b1; inst_addr = 32'h9000;
        tick();
        check("to_grant", 64'({l2_req, l2_op}), 64'b100);
        for (int k = 0; k < 7; k++) tick();
        check("to_not_yet", 64'(timeout_err), 64'd0);
        tick();
        check("to_set", 64'(timeout_err), 64'd1);
        tick(); tick();
        pulse_ack();
        inst_req = 1'b0;
        check("to_late_ack", 64'({inst_ack, timeout_err}), 64'b11);
        tick(); tick();
        check("to_sticky", 64'(timeout_err), 64'd1);

        // Asynchronous reset mid-BUSY
        inst_req = 1'b1; inst_addr = 32'hA000;
        tick();
        check("rb_grant", 64'(l2_req), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rb_async", 64'({l2_req, inst_ack, data_ack, wb_ack, arb_busy, timeout_err}), 64'd0);
        tick();
        rst_n = 1'b1;
        check("rb_held", 64'(l2_req), 64'd0);
        tick();
        check("rb_regrant", 64'({l2_req, l2_op, l2_addr}), 64'({1'b1, 2'b00, 32'hA000}));
        pulse_ack();
        inst_req = 1'b0;
        check("rb_ack", 64'(inst_ack), 64'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety bound on total simulation time
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (rst_n && ($countones({inst_ack, data_ack, wb_ack}) > 1)) begin
            fails++;
            tests++;
            $display("FAIL onehot_ack: got %b expected at most one set", {inst_ack, data_ack, wb_ack});
        end
    end

endmodule
`default_nettype wire
